// File: rtl/image_stream_source_if.sv
// Pixel stream bus with valid/ready flow control and per-pixel position tags.
interface image_stream_source_if #(
  parameter int unsigned PIXEL_W = 8,
  parameter int unsigned CH_W    = 1
);
  logic [PIXEL_W-1:0] Pixel_Out;
  logic               Pixel_valid;
  logic               Pixel_ready;
  logic [CH_W-1:0]    Channel;
  logic               row_last;
  logic               frame_last;

  modport master (
    output Pixel_Out, Pixel_valid, Channel, row_last, frame_last,
    input  Pixel_ready
  );

  modport slave (
    input  Pixel_Out, Pixel_valid, Channel, row_last, frame_last,
    output Pixel_ready
  );
endinterface

// File: rtl/image_stream_source.sv
// Streams a frame held in an internal pixel buffer, linear address order, channels innermost.
// A one-deep skid stage behind the synchronous read keeps full throughput under backpressure.
module image_stream_source #(
  parameter int unsigned PIXEL_W  = 8,
  parameter int unsigned IMG_W    = 28,
  parameter int unsigned IMG_H    = 28,
  parameter int unsigned CHANNELS = 1,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [PIXEL_W-1:0]   wr_data,
  input  logic                 start,
  input  logic                 loop_mode,
  image_stream_source_if.master px,
  output logic                 busy,
  output logic                 done
);
  localparam int unsigned N       = IMG_W * IMG_H * CHANNELS;
  localparam int unsigned ROW_LEN = IMG_W * CHANNELS;
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] LastCol  = ADDR_W'(ROW_LEN - 1);
  localparam logic [CH_W-1:0]   LastCh   = CH_W'(CHANNELS - 1);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            row_last;
    logic            frame_last;
  } meta_t;

  state_e state_q, state_d;

  logic [PIXEL_W-1:0] mem [N];
  logic [PIXEL_W-1:0] rdata_q;
  logic [ADDR_W-1:0]  rd_addr_q, col_q;
  logic [CH_W-1:0]    ch_q;
  logic               rd_pend_q;
  meta_t              pend_meta_q;

  logic               valid_q, skid_valid_q;
  logic [PIXEL_W-1:0] out_data_q, skid_data_q;
  meta_t              out_meta_q, skid_meta_q;

  logic       pop, issue, finish;
  logic [1:0] occ;

  assign pop    = valid_q & px.Pixel_ready;
  assign occ    = 2'(valid_q) + 2'(skid_valid_q) + 2'(rd_pend_q);
  // Only read when the result is guaranteed a slot even if the consumer stalls next cycle.
  assign issue  = (state_q == StStream) && (occ <= 2'(pop) + 2'd1);
  assign finish = pop && out_meta_q.frame_last && !loop_mode;

  always_ff @(posedge clock) begin
    if (wr_en && (wr_addr <= LastAddr)) mem[wr_addr] <= wr_data;
    if (issue) rdata_q <= mem[rd_addr_q];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StStream;
      StStream: if (finish) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_addr_q   <= '0;
      col_q       <= '0;
      ch_q        <= '0;
      rd_pend_q   <= 1'b0;
      pend_meta_q <= '0;
    end else begin
      rd_pend_q <= issue && !finish;
      if (state_q == StIdle && start) begin
        rd_addr_q <= '0;
        col_q     <= '0;
        ch_q      <= '0;
      end else if (issue) begin
        pend_meta_q <= '{ch: ch_q, row_last: (col_q == LastCol),
                         frame_last: (rd_addr_q == LastAddr)};
        rd_addr_q   <= (rd_addr_q == LastAddr) ? '0 : rd_addr_q + 1'b1;
        col_q       <= (col_q == LastCol) ? '0 : col_q + 1'b1;
        ch_q        <= (ch_q == LastCh) ? '0 : ch_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
      out_meta_q   <= '0;
      skid_meta_q  <= '0;
    end else if (finish) begin
      // Drop any prefetched wrap-around pixels when the frame sequence ends.
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!valid_q || pop) begin
      if (skid_valid_q) begin
        valid_q      <= 1'b1;
        out_data_q   <= skid_data_q;
        out_meta_q   <= skid_meta_q;
        skid_valid_q <= rd_pend_q;
        if (rd_pend_q) begin
          skid_data_q <= rdata_q;
          skid_meta_q <= pend_meta_q;
        end
      end else begin
        valid_q <= rd_pend_q;
        if (rd_pend_q) begin
          out_data_q <= rdata_q;
          out_meta_q <= pend_meta_q;
        end
      end
    end else if (rd_pend_q) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= rdata_q;
      skid_meta_q  <= pend_meta_q;
    end
  end

  assign px.Pixel_Out   = out_data_q;
  assign px.Pixel_valid = valid_q;
  assign px.Channel     = out_meta_q.ch;
  assign px.row_last    = valid_q & out_meta_q.row_last;
  assign px.frame_last  = valid_q & out_meta_q.frame_last;
  assign busy           = (state_q == StStream);
  assign done           = (state_q == StDone);
endmodule

// File: tb/tb_image_stream_source.sv
// Directed bench: default 28x28x1 instance plus a 4x4x3 instance for channel sequencing.
module tb_image_stream_source;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic       wr_en, start, loop_mode, busy, done;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_en3, start3, loop3, busy3, done3;
  logic [5:0] wr_addr3;
  logic [7:0] wr_data3;

  image_stream_source_if #(.PIXEL_W(8), .CH_W(1)) px ();
  image_stream_source_if #(.PIXEL_W(8), .CH_W(2)) px3 ();

  image_stream_source dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .loop_mode(loop_mode), .px(px), .busy(busy), .done(done)
  );

  image_stream_source #(.IMG_W(4), .IMG_H(4), .CHANNELS(3), .ADDR_W(6)) dut3 (
    .clock(clock), .reset(reset), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3),
    .start(start3), .loop_mode(loop3), .px(px3), .busy(busy3), .done(done3)
  );

  int checks = 0;
  int fails  = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_mem();
    for (int i = 0; i < 784; i++) begin
      wr_en = 1'b1; wr_addr = 10'(i); wr_data = 8'(i);
      wr_en3 = (i < 48); wr_addr3 = 6'(i); wr_data3 = 8'(i * 3 + 1);
      tick();
    end
    wr_en = 1'b0; wr_en3 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (px.Pixel_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", px.Pixel_valid); end
    checks++; if (px.Pixel_Out !== 8'd0) begin fails++; $display("FAIL reset_data: got %0d want 0", px.Pixel_Out); end
    checks++; if (px.Channel !== 1'b0) begin fails++; $display("FAIL reset_channel: got %0d want 0", px.Channel); end
    checks++; if ({px.row_last, px.frame_last} !== 2'b00) begin fails++; $display("FAIL reset_last: got %b want 00", {px.row_last, px.frame_last}); end
    checks++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL reset_busy_done: got %b want 00", {busy, done}); end
    checks++; if ({px3.Pixel_valid, busy3, done3} !== 3'b000) begin fails++; $display("FAIL reset_dut3: got %b want 000", {px3.Pixel_valid, busy3, done3}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_frame();
    pulse_start();
    checks++; if ({busy, px.Pixel_valid} !== 2'b10) begin fails++; $display("FAIL frame_k: busy,valid got %b want 10", {busy, px.Pixel_valid}); end
    tick();
    checks++; if (px.Pixel_valid !== 1'b0) begin fails++; $display("FAIL frame_k1_valid: got %b want 0", px.Pixel_valid); end
    tick();
    for (int idx = 0; idx < 784; idx++) begin
      checks++;
      if (px.Pixel_valid !== 1'b1 || px.Pixel_Out !== 8'(idx) ||
          px.row_last !== (idx % 28 == 27) || px.frame_last !== (idx == 783)) begin
        fails++;
        $display("FAIL frame_pix %0d: valid=%b data=%0d rl=%b fl=%b want 1 %0d %b %b", idx,
                 px.Pixel_valid, px.Pixel_Out, px.row_last, px.frame_last, idx % 256,
                 idx % 28 == 27, idx == 783);
      end
      tick();
    end
    checks++; if ({px.Pixel_valid, done, busy} !== 3'b010) begin fails++; $display("FAIL frame_end: valid,done,busy got %b want 010", {px.Pixel_valid, done, busy}); end
    tick();
    checks++; if ({done, busy} !== 2'b00) begin fails++; $display("FAIL frame_done_pulse: done,busy got %b want 00", {done, busy}); end
  endtask

  task automatic test_backpressure();
    bit found = 0;
    bit seen_done = 0;
    pulse_start();
    for (int c = 0; c < 300; c++) begin
      if (px.Pixel_valid && px.Pixel_Out == 8'd100) begin found = 1; break; end
      tick();
    end
    checks++; if (!found) begin fails++; $display("FAIL bp_reach100: pixel 100 not presented within bound"); end
    px.Pixel_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (px.Pixel_valid !== 1'b1 || px.Pixel_Out !== 8'd100) begin
        fails++; $display("FAIL bp_hold %0d: valid=%b data=%0d want 1 100", k, px.Pixel_valid, px.Pixel_Out);
      end
    end
    px.Pixel_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (px.Pixel_valid !== 1'b1 || px.Pixel_Out !== 8'(100 + k)) begin
        fails++; $display("FAIL bp_resume %0d: valid=%b data=%0d want 1 %0d", k, px.Pixel_valid, px.Pixel_Out, 100 + k);
      end
      tick();
    end
    for (int c = 0; c < 1000; c++) begin
      if (done) begin seen_done = 1; break; end
      tick();
    end
    checks++; if (!seen_done) begin fails++; $display("FAIL bp_done: done not seen within bound"); end
    tick();
  endtask

  task automatic test_channels();
    int idx = 0;
    int n_done = 0;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (done3) n_done++;
      if (px3.Pixel_valid) begin
        checks++;
        if (px3.Channel !== 2'(idx % 3) || px3.Pixel_Out !== 8'(idx * 3 + 1) ||
            px3.row_last !== (idx % 12 == 11) || px3.frame_last !== (idx == 47)) begin
          fails++;
          $display("FAIL ch_pix %0d: ch=%0d data=%0d rl=%b fl=%b want %0d %0d %b %b", idx,
                   px3.Channel, px3.Pixel_Out, px3.row_last, px3.frame_last, idx % 3,
                   idx * 3 + 1, idx % 12 == 11, idx == 47);
        end
        idx++;
      end
      tick();
    end
    checks++; if (idx != 48) begin fails++; $display("FAIL ch_count: got %0d transfers want 48", idx); end
    checks++; if (n_done != 1) begin fails++; $display("FAIL ch_done: got %0d pulses want 1", n_done); end
  endtask

  task automatic test_loop();
    int idx = 0;
    int n_done = 0;
    bit started = 0;
    loop_mode = 1'b1;
    pulse_start();
    for (int c = 0; c < 2000; c++) begin
      if (done) n_done++;
      if (px.Pixel_valid) begin
        started = 1;
        checks++;
        if (px.Pixel_Out !== 8'(idx % 784) || px.frame_last !== (idx % 784 == 783)) begin
          fails++;
          $display("FAIL loop_pix %0d: data=%0d fl=%b want %0d %b", idx, px.Pixel_Out,
                   px.frame_last, (idx % 784) % 256, idx % 784 == 783);
        end
        idx++;
        if (idx == 1000) loop_mode = 1'b0;
      end else if (started) begin
        break;
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done) n_done++;
    end
    checks++; if (idx != 1568) begin fails++; $display("FAIL loop_count: got %0d transfers want 1568", idx); end
    checks++; if (n_done != 1) begin fails++; $display("FAIL loop_done: got %0d pulses want 1", n_done); end
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    bit seen_done = 0;
    pulse_start();
    for (int c = 0; c < 400; c++) begin
      if (px.Pixel_valid) begin
        if (idx == 300) break;
        idx++;
      end
      tick();
    end
    checks++; if (idx != 300) begin fails++; $display("FAIL rst_reach300: got %0d want 300", idx); end
    reset = 1'b1;
    #1;
    checks++;
    if ({px.Pixel_valid, busy, done, px.row_last, px.frame_last} !== 5'b0 || px.Pixel_Out !== 8'd0 ||
        px.Channel !== 1'b0) begin
      fails++;
      $display("FAIL rst_async: valid=%b busy=%b done=%b data=%0d want all 0", px.Pixel_valid, busy,
               done, px.Pixel_Out);
    end
    tick();
    reset = 1'b0;
    tick();
    pulse_start();
    tick(); tick();
    for (int i = 0; i < 784; i++) begin
      checks++;
      if (px.Pixel_valid !== 1'b1 || px.Pixel_Out !== 8'(i)) begin
        fails++; $display("FAIL rst_restream %0d: valid=%b data=%0d want 1 %0d", i, px.Pixel_valid, px.Pixel_Out, i % 256);
      end
      tick();
    end
    seen_done = done;
    checks++; if (!seen_done) begin fails++; $display("FAIL rst_done: done=%b want 1", done); end
    tick();
  endtask

  task automatic test_start_ignored();
    int idx = 0;
    bit seen_done = 0;
    pulse_start();
    for (int c = 0; c < 1000; c++) begin
      if (done) begin seen_done = 1; break; end
      if (px.Pixel_valid) begin
        checks++;
        if (px.Pixel_Out !== 8'(idx)) begin
          fails++; $display("FAIL restart_pix %0d: data=%0d want %0d", idx, px.Pixel_Out, idx % 256);
        end
        if (idx == 50) start = 1'b1;
        idx++;
      end
      tick();
      start = 1'b0;
    end
    checks++; if (!seen_done || idx != 784) begin fails++; $display("FAIL restart_count: done=%b got %0d transfers want 784", seen_done, idx); end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({busy, px.Pixel_valid} !== 2'b00) begin
        fails++; $display("FAIL done_start_ignored %0d: busy,valid got %b want 00", k, {busy, px.Pixel_valid});
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; loop_mode = 1'b0;
    wr_en3 = 1'b0; wr_addr3 = '0; wr_data3 = '0; start3 = 1'b0; loop3 = 1'b0;
    px.Pixel_ready = 1'b1;
    px3.Pixel_ready = 1'b1;
    test_reset();
    load_mem();
    test_frame();
    test_backpressure();
    test_channels();
    test_loop();
    test_reset_mid();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
